// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants: parity modes and receiver state encodings.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line plus received-word bundle between a line driver and the receiver.
interface uart_rx_if #(
   parameter int P_DATA_WIDTH = 8
);

   logic                    uart_rx;
   logic [P_DATA_WIDTH-1:0] rx_data;
   logic                    rx_valid;
   logic                    rx_parity_err;
   logic                    rx_frame_err;

   modport master (
      output uart_rx,
      input  rx_data,
      input  rx_valid,
      input  rx_parity_err,
      input  rx_frame_err
   );

   modport slave (
      input  uart_rx,
      output rx_data,
      output rx_valid,
      output rx_parity_err,
      output rx_frame_err
   );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-FF synchronizer for the async rx line plus a registered falling-edge detect.
module uart_rx_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_sync,
   output logic o_fall
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Reset to the idle-high level so releasing reset on an idle line never looks like an edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= i_async;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign o_sync = sync_q;
   assign o_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: mid-bit sampling, optional parity, 1 or 2 stop bits, error flags.
module uart_rx
   import uart_pkg::*;
#(
   parameter int P_SYSTEM_CLK      = 50_000_000,
   parameter int P_UART_BAUND_RATE = 9600,
   parameter int P_UART_DATA_WIDTH = 8,
   parameter int P_UART_STOP_WIDTH = 1,
   parameter int P_UART_CHECK      = 0
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_uart_rx,
   output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
   output logic                         o_user_rx_valid,
   output logic                         o_user_rx_parity_err,
   output logic                         o_user_rx_frame_err
);

   localparam int N  = P_SYSTEM_CLK / P_UART_BAUND_RATE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int BW = $clog2(P_UART_DATA_WIDTH + 1);

   localparam logic [CW-1:0] CNT_HALF  = CW'(N / 2);
   localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(P_UART_DATA_WIDTH - 1);
   localparam logic          STOP_LAST = 1'(P_UART_STOP_WIDTH - 1);

   logic rx_sync;
   logic rx_fall;

   uart_rx_sync u_sync (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_async (i_uart_rx),
      .o_sync  (rx_sync),
      .o_fall  (rx_fall)
   );

   rx_state_e                    state_q;
   logic [CW-1:0]                cnt_q;
   logic [BW-1:0]                bit_cnt_q;
   logic                         stop_cnt_q;
   logic [P_UART_DATA_WIDTH-1:0] shift_q;
   logic                         par_q;
   logic                         perr_q;
   logic                         ferr_q;
   logic [P_UART_DATA_WIDTH-1:0] data_q;
   logic                         valid_q;
   logic                         perr_out_q;
   logic                         ferr_out_q;

   logic bit_tick;
   logic ones_odd;
   logic par_bad_d;

   // After the start-bit mid-sample the counter restarts, so every later mid-sample lands N cycles on.
   assign bit_tick = (cnt_q == CNT_LAST);
   assign ones_odd = par_q ^ rx_sync;

   always_comb begin
      par_bad_d = 1'b0;
      if (P_UART_CHECK == PARITY_ODD)  par_bad_d = ~ones_odd;
      if (P_UART_CHECK == PARITY_EVEN) par_bad_d = ones_odd;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rx_fall) begin
                  state_q <= ST_START;
                  cnt_q   <= '0;
               end
            end
            ST_START: begin
               if (cnt_q == CNT_HALF) begin
                  cnt_q      <= '0;
                  bit_cnt_q  <= '0;
                  stop_cnt_q <= 1'b0;
                  par_q      <= 1'b0;
                  perr_q     <= 1'b0;
                  ferr_q     <= 1'b0;
                  state_q    <= rx_sync ? ST_IDLE : ST_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_DATA: begin
               if (bit_tick) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_sync, shift_q[P_UART_DATA_WIDTH-1:1]};
                  par_q   <= par_q ^ rx_sync;
                  if (bit_cnt_q == BIT_LAST) begin
                     bit_cnt_q <= '0;
                     state_q   <= (P_UART_CHECK != PARITY_NONE) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_PARITY: begin
               if (bit_tick) begin
                  cnt_q   <= '0;
                  perr_q  <= par_bad_d;
                  state_q <= ST_STOP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_STOP: begin
               if (bit_tick) begin
                  cnt_q <= '0;
                  if (stop_cnt_q == STOP_LAST) begin
                     data_q     <= shift_q;
                     perr_out_q <= perr_q;
                     ferr_out_q <= ferr_q | ~rx_sync;
                     valid_q    <= 1'b1;
                     stop_cnt_q <= 1'b0;
                     state_q    <= ST_IDLE;
                  end else begin
                     ferr_q     <= ferr_q | ~rx_sync;
                     stop_cnt_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_user_rx_data       = data_q;
   assign o_user_rx_valid      = valid_q;
   assign o_user_rx_parity_err = perr_out_q;
   assign o_user_rx_frame_err  = ferr_out_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (8N1 and 8E1 instances, N=16).
module tb_uart_rx;
   import uart_pkg::*;

   localparam int NB = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   uart_rx_if #(.P_DATA_WIDTH(8)) ifa ();
   uart_rx_if #(.P_DATA_WIDTH(8)) ifb ();

   uart_rx #(
      .P_SYSTEM_CLK(16), .P_UART_BAUND_RATE(1), .P_UART_DATA_WIDTH(8),
      .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)
   ) u_dut (
      .i_clk(clk), .i_rst(rst), .i_uart_rx(ifa.uart_rx),
      .o_user_rx_data(ifa.rx_data), .o_user_rx_valid(ifa.rx_valid),
      .o_user_rx_parity_err(ifa.rx_parity_err), .o_user_rx_frame_err(ifa.rx_frame_err)
   );

   uart_rx #(
      .P_SYSTEM_CLK(16), .P_UART_BAUND_RATE(1), .P_UART_DATA_WIDTH(8),
      .P_UART_STOP_WIDTH(1), .P_UART_CHECK(2)
   ) u_dut_par (
      .i_clk(clk), .i_rst(rst), .i_uart_rx(ifb.uart_rx),
      .o_user_rx_data(ifb.rx_data), .o_user_rx_valid(ifb.rx_valid),
      .o_user_rx_parity_err(ifb.rx_parity_err), .o_user_rx_frame_err(ifb.rx_frame_err)
   );

   int         vcnt_a = 0;
   int         vcnt_b = 0;
   int         wide   = 0;
   logic       prev_va = 1'b0;
   logic       prev_vb = 1'b0;
   logic [9:0] log_a[$];

   always @(negedge clk) begin
      if (ifa.rx_valid === 1'b1) begin
         vcnt_a++;
         log_a.push_back({ifa.rx_parity_err, ifa.rx_frame_err, ifa.rx_data});
         if (prev_va === 1'b1) wide++;
      end
      prev_va = ifa.rx_valid;
   end

   always @(negedge clk) begin
      if (ifb.rx_valid === 1'b1) begin
         vcnt_b++;
         if (prev_vb === 1'b1) wide++;
      end
      prev_vb = ifb.rx_valid;
   end

   task automatic drive_line(input bit sel, input logic v, input int cycles);
      if (sel) ifb.uart_rx = v;
      else     ifa.uart_rx = v;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                             input logic par_bit, input logic stop_lvl);
      drive_line(sel, 1'b0, NB);
      for (int i = 0; i < 8; i++) drive_line(sel, d[i], NB);
      if (use_par) drive_line(sel, par_bit, NB);
      drive_line(sel, stop_lvl, NB);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(negedge clk);
      total++; if (ifa.rx_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", ifa.rx_data); else passed++;
      total++; if (ifa.rx_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", ifa.rx_valid); else passed++;
      total++; if (ifa.rx_parity_err !== 1'b0) $display("FAIL reset_perr got=%b exp=0", ifa.rx_parity_err); else passed++;
      total++; if (ifa.rx_frame_err !== 1'b0) $display("FAIL reset_ferr got=%b exp=0", ifa.rx_frame_err); else passed++;
      total++; if (u_dut.state_q !== ST_IDLE) $display("FAIL reset_state got=%0d exp=%0d", u_dut.state_q, ST_IDLE); else passed++;
      rst = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_8n1();
      int base = vcnt_a;
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      drive_line(1'b0, 1'b1, 8);
      total++; if (vcnt_a - base !== 1) $display("FAIL a5_count got=%0d exp=1", vcnt_a - base); else passed++;
      total++; if (ifa.rx_data !== 8'hA5) $display("FAIL a5_data got=%h exp=a5", ifa.rx_data); else passed++;
      total++; if (ifa.rx_parity_err !== 1'b0) $display("FAIL a5_perr got=%b exp=0", ifa.rx_parity_err); else passed++;
      total++; if (ifa.rx_frame_err !== 1'b0) $display("FAIL a5_ferr got=%b exp=0", ifa.rx_frame_err); else passed++;
   endtask

   task automatic test_parity();
      int base = vcnt_b;
      send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
      drive_line(1'b1, 1'b1, 8);
      total++; if (vcnt_b - base !== 1) $display("FAIL par_ok_count got=%0d exp=1", vcnt_b - base); else passed++;
      total++; if (ifb.rx_data !== 8'h07) $display("FAIL par_ok_data got=%h exp=07", ifb.rx_data); else passed++;
      total++; if (ifb.rx_parity_err !== 1'b0) $display("FAIL par_ok_perr got=%b exp=0", ifb.rx_parity_err); else passed++;
      total++; if (ifb.rx_frame_err !== 1'b0) $display("FAIL par_ok_ferr got=%b exp=0", ifb.rx_frame_err); else passed++;
      base = vcnt_b;
      send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
      drive_line(1'b1, 1'b1, 8);
      total++; if (vcnt_b - base !== 1) $display("FAIL par_bad_count got=%0d exp=1", vcnt_b - base); else passed++;
      total++; if (ifb.rx_data !== 8'h07) $display("FAIL par_bad_data got=%h exp=07", ifb.rx_data); else passed++;
      total++; if (ifb.rx_parity_err !== 1'b1) $display("FAIL par_bad_perr got=%b exp=1", ifb.rx_parity_err); else passed++;
      total++; if (ifb.rx_frame_err !== 1'b0) $display("FAIL par_bad_ferr got=%b exp=0", ifb.rx_frame_err); else passed++;
   endtask

   task automatic test_glitch();
      int base = vcnt_a;
      drive_line(1'b0, 1'b0, 5);
      drive_line(1'b0, 1'b1, 40);
      total++; if (vcnt_a - base !== 0) $display("FAIL glitch_count got=%0d exp=0", vcnt_a - base); else passed++;
      total++; if (u_dut.state_q !== ST_IDLE) $display("FAIL glitch_state got=%0d exp=%0d", u_dut.state_q, ST_IDLE); else passed++;
   endtask

   task automatic test_frame_err();
      int base = vcnt_a;
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
      drive_line(1'b0, 1'b1, 24);
      total++; if (vcnt_a - base !== 1) $display("FAIL ferr_count got=%0d exp=1", vcnt_a - base); else passed++;
      total++; if (ifa.rx_data !== 8'h3C) $display("FAIL ferr_data got=%h exp=3c", ifa.rx_data); else passed++;
      total++; if (ifa.rx_frame_err !== 1'b1) $display("FAIL ferr_flag got=%b exp=1", ifa.rx_frame_err); else passed++;
      total++; if (ifa.rx_parity_err !== 1'b0) $display("FAIL ferr_perr got=%b exp=0", ifa.rx_parity_err); else passed++;
   endtask

   task automatic test_back_to_back();
      int base = vcnt_a;
      int lb   = log_a.size();
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
      send_frame(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1);
      drive_line(1'b0, 1'b1, 16);
      total++; if (vcnt_a - base !== 2) $display("FAIL b2b_count got=%0d exp=2", vcnt_a - base); else passed++;
      if (log_a.size() >= lb + 2) begin
         total++; if (log_a[lb] !== 10'h055) $display("FAIL b2b_first got=%h exp=055", log_a[lb]); else passed++;
         total++; if (log_a[lb+1] !== 10'h0AA) $display("FAIL b2b_second got=%h exp=0aa", log_a[lb+1]); else passed++;
      end else begin
         total++;
         $display("FAIL b2b_log got=%0d entries exp=%0d", log_a.size() - lb, 2);
      end
   endtask

   task automatic test_reset_mid();
      int base;
      logic [7:0] d = 8'h5A;
      drive_line(1'b0, 1'b0, NB);
      for (int i = 0; i < 3; i++) drive_line(1'b0, d[i], NB);
      drive_line(1'b0, d[3], 6);
      base = vcnt_a;
      rst = 1'b1;
      drive_line(1'b0, 1'b1, 3);
      rst = 1'b0;
      drive_line(1'b0, 1'b1, 40);
      total++; if (vcnt_a - base !== 0) $display("FAIL rstmid_count got=%0d exp=0", vcnt_a - base); else passed++;
      total++; if (ifa.rx_data !== 8'h00) $display("FAIL rstmid_data got=%h exp=00", ifa.rx_data); else passed++;
      total++; if (ifa.rx_frame_err !== 1'b0) $display("FAIL rstmid_ferr got=%b exp=0", ifa.rx_frame_err); else passed++;
      base = vcnt_a;
      send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
      drive_line(1'b0, 1'b1, 8);
      total++; if (vcnt_a - base !== 1) $display("FAIL rstmid_next_count got=%0d exp=1", vcnt_a - base); else passed++;
      total++; if (ifa.rx_data !== 8'h81) $display("FAIL rstmid_next_data got=%h exp=81", ifa.rx_data); else passed++;
   endtask

   task automatic test_break();
      int base = vcnt_a;
      drive_line(1'b0, 1'b0, 14 * NB);
      total++; if (vcnt_a - base !== 1) $display("FAIL break_count got=%0d exp=1", vcnt_a - base); else passed++;
      total++; if (ifa.rx_data !== 8'h00) $display("FAIL break_data got=%h exp=00", ifa.rx_data); else passed++;
      total++; if (ifa.rx_frame_err !== 1'b1) $display("FAIL break_ferr got=%b exp=1", ifa.rx_frame_err); else passed++;
      drive_line(1'b0, 1'b1, 40);
      total++; if (vcnt_a - base !== 1) $display("FAIL break_release_count got=%0d exp=1", vcnt_a - base); else passed++;
   endtask

   task automatic test_pulse_width();
      total++; if (wide !== 0) $display("FAIL valid_width got=%0d multi-cycle pulses exp=0", wide); else passed++;
   endtask

   initial begin
      ifa.uart_rx = 1'b1;
      ifb.uart_rx = 1'b1;
      test_reset();
      test_8n1();
      test_parity();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_reset_mid();
      test_break();
      test_pulse_width();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
